// File: rtl/alt_dfe_dprio_regbank_if.sv
// DPRIO register-bank bus: request/handshake from the initiator plus the
// bank's busy, read data and address-remap outputs.
interface alt_dfe_dprio_regbank_if #(
    parameter int DPRIO_ADDR_WIDTH = 16,
    parameter int DPRIO_DATA_WIDTH = 16
);
    logic                        i_dprio_wren;
    logic                        i_dprio_rden;
    logic [DPRIO_ADDR_WIDTH-1:0] i_dprio_addr;
    logic [DPRIO_DATA_WIDTH-1:0] i_dprio_data;
    logic                        o_dprio_busy;
    logic [DPRIO_DATA_WIDTH-1:0] o_dprio_out;
    logic [11:0]                 o_remap_address;

    modport master (
        output i_dprio_wren, i_dprio_rden, i_dprio_addr, i_dprio_data,
        input  o_dprio_busy, o_dprio_out, o_remap_address
    );

    modport slave (
        input  i_dprio_wren, i_dprio_rden, i_dprio_addr, i_dprio_data,
        output o_dprio_busy, o_dprio_out, o_remap_address
    );
endinterface

// File: rtl/alt_dfe_dprio_regbank.sv
// DPRIO register bank: NUM_REGS words at BASE_ADDR, word 0 is a read-only ID.
// Each accepted access keeps busy high for a fixed latency, then commits.
module alt_dfe_dprio_regbank #(
    parameter int                          DPRIO_ADDR_WIDTH = 16,
    parameter int                          DPRIO_DATA_WIDTH = 16,
    parameter int                          NUM_REGS         = 16,
    parameter logic [DPRIO_ADDR_WIDTH-1:0] BASE_ADDR        = 16'h0000,
    parameter int                          WR_LATENCY       = 4,
    parameter int                          RD_LATENCY       = 3,
    parameter logic [DPRIO_DATA_WIDTH-1:0] ID_VALUE         = 16'hD0E1
) (
    input logic                     i_dprio_clk,
    input logic                     i_resetn,
    alt_dfe_dprio_regbank_if.slave  bus
);
    localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int OFF_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [DPRIO_ADDR_WIDTH:0] LIMIT =
        {1'b0, BASE_ADDR} + (DPRIO_ADDR_WIDTH+1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        busy_q, busy_d;
    logic [DPRIO_DATA_WIDTH-1:0] out_q, out_d;
    logic                        op_wr_q, op_wr_d;
    logic [OFF_W-1:0]            off_q, off_d;
    logic [DPRIO_DATA_WIDTH-1:0] data_q, data_d;
    logic [DPRIO_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                        commit_we;
    logic                        in_range;
    logic [OFF_W-1:0]            req_off;
    logic [DPRIO_DATA_WIDTH-1:0] rd_word;

    // Decode the live address: range check and word offset relative to BASE_ADDR.
    always_comb begin
        in_range = ({1'b0, bus.i_dprio_addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, bus.i_dprio_addr} <  LIMIT);
        req_off  = OFF_W'(bus.i_dprio_addr - BASE_ADDR);
        rd_word  = (off_q == '0) ? ID_VALUE : regs_q[off_q];
    end

    assign bus.o_remap_address = in_range ? 12'(req_off) : 12'hfff;
    assign bus.o_dprio_busy    = busy_q;
    assign bus.o_dprio_out     = out_q;

    // Next-state logic: accept in-range requests in idle, count down while busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        out_d     = out_q;
        op_wr_d   = op_wr_q;
        off_d     = off_q;
        data_d    = data_q;
        commit_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((bus.i_dprio_wren || bus.i_dprio_rden) && in_range) begin
                    // A simultaneous read/write request is treated as a write.
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    op_wr_d = bus.i_dprio_wren;
                    off_d   = req_off;
                    data_d  = bus.i_dprio_data;
                    cnt_d   = bus.i_dprio_wren ? CNT_W'(WR_LATENCY) : CNT_W'(RD_LATENCY);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (op_wr_q) begin
                        // Word 0 holds the ID and silently ignores writes.
                        commit_we = (off_q != '0);
                    end else begin
                        out_d = rd_word;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and latched-request registers; reset aborts any operation in flight.
    always_ff @(posedge i_dprio_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            out_q   <= '0;
            op_wr_q <= 1'b0;
            off_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
            op_wr_q <= op_wr_d;
            off_q   <= off_d;
            data_q  <= data_d;
        end
    end

    // Register words; a write lands only on the final busy edge.
    always_ff @(posedge i_dprio_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_we) begin
            regs_q[off_q] <= data_q;
        end
    end
endmodule

// File: tb/tb_alt_dfe_dprio_regbank.sv
// Bench for alt_dfe_dprio_regbank: directed vector table, reset and
// back-to-back sequences, then random accesses against a word-array model.
module tb_alt_dfe_dprio_regbank;
    localparam int          NREGS  = 16;
    localparam int          WR_LAT = 4;
    localparam int          RD_LAT = 3;
    localparam logic [15:0] ID     = 16'hD0E1;

    logic clk;
    logic resetn;

    alt_dfe_dprio_regbank_if #(.DPRIO_ADDR_WIDTH(16), .DPRIO_DATA_WIDTH(16)) bus_if ();

    alt_dfe_dprio_regbank dut (
        .i_dprio_clk (clk),
        .i_resetn    (resetn),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
        int          exp_busy;
        logic [15:0] exp_out;
        logic [11:0] exp_remap;
    } vec_t;

    vec_t tbl [15];

    logic [15:0] model_mem [NREGS];
    logic [15:0] model_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Starts at posedge+1. Drives a request, holds it until busy is seen,
    // then counts consecutive busy cycles. Returns remap seen before acceptance.
    task automatic do_op(input logic wr, input logic rd, input logic [15:0] a,
                         input logic [15:0] d, output int bcnt, output logic [11:0] remap);
        bit acc;
        bus_if.i_dprio_wren = wr;
        bus_if.i_dprio_rden = rd;
        bus_if.i_dprio_addr = a;
        bus_if.i_dprio_data = d;
        #1;
        remap = bus_if.o_remap_address;
        acc = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (bus_if.o_dprio_busy) begin
                acc = 1'b1;
                break;
            end
        end
        bus_if.i_dprio_wren = 1'b0;
        bus_if.i_dprio_rden = 1'b0;
        bus_if.i_dprio_addr = 16'($urandom);
        bus_if.i_dprio_data = 16'($urandom);
        bcnt = 0;
        if (acc) begin
            bcnt = 1;
            while (bus_if.o_dprio_busy && bcnt < 40) begin
                @(posedge clk); #1;
                if (bus_if.o_dprio_busy) bcnt++;
            end
        end
    endtask

    initial begin
        int          bc;
        int          run_hi1, run_lo, run_hi2;
        logic [11:0] rm;
        logic [15:0] a, d;
        int          op;
        bit          in_rng;

        // wr, rd, addr, data, busy cycles, out after, remap
        tbl[0]  = '{1'b1, 1'b0, 16'h0003, 16'h1234, 4, 16'h0000, 12'h003};
        tbl[1]  = '{1'b0, 1'b1, 16'h0003, 16'h0000, 3, 16'h1234, 12'h003};
        tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 3, 16'hD0E1, 12'h000};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 4, 16'hD0E1, 12'h000};
        tbl[4]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 3, 16'hD0E1, 12'h000};
        tbl[5]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 0, 16'hD0E1, 12'hfff};
        tbl[6]  = '{1'b1, 1'b0, 16'h0010, 16'h5555, 0, 16'hD0E1, 12'hfff};
        tbl[7]  = '{1'b1, 1'b1, 16'h0005, 16'hA5A5, 4, 16'hD0E1, 12'h005};
        tbl[8]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 3, 16'hA5A5, 12'h005};
        tbl[9]  = '{1'b0, 1'b1, 16'h000F, 16'h0000, 3, 16'h0000, 12'h00f};
        tbl[10] = '{1'b1, 1'b0, 16'h000F, 16'hBEEF, 4, 16'h0000, 12'h00f};
        tbl[11] = '{1'b0, 1'b1, 16'h000F, 16'h0000, 3, 16'hBEEF, 12'h00f};
        tbl[12] = '{1'b1, 1'b1, 16'hFFFF, 16'h7777, 0, 16'hBEEF, 12'hfff};
        tbl[13] = '{1'b0, 1'b1, 16'h0003, 16'h0000, 3, 16'h1234, 12'h003};
        tbl[14] = '{1'b0, 1'b1, 16'h0001, 16'h0000, 3, 16'h0000, 12'h001};

        resetn = 1'b0;
        bus_if.i_dprio_wren = 1'b0;
        bus_if.i_dprio_rden = 1'b0;
        bus_if.i_dprio_addr = 16'h0000;
        bus_if.i_dprio_data = 16'h0000;
        #2;
        chk("reset_busy", 32'(bus_if.o_dprio_busy), 32'd0);
        chk("reset_out", 32'(bus_if.o_dprio_out), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            do_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, bc, rm);
            chk($sformatf("tbl%0d_remap", i), 32'(rm), 32'(tbl[i].exp_remap));
            chk($sformatf("tbl%0d_busy", i), 32'(bc), 32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_out", i), 32'(bus_if.o_dprio_out), 32'(tbl[i].exp_out));
            @(posedge clk); #1;
        end

        // Reset on the second busy cycle of a write to word 2
        bus_if.i_dprio_wren = 1'b1;
        bus_if.i_dprio_addr = 16'h0002;
        bus_if.i_dprio_data = 16'h00FF;
        bc = 0;
        while (!bus_if.o_dprio_busy && bc < 8) begin
            @(posedge clk); #1; bc++;
        end
        chk("rst_seq_accept", 32'(bus_if.o_dprio_busy), 32'd1);
        bus_if.i_dprio_wren = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("rst_seq_busy", 32'(bus_if.o_dprio_busy), 32'd0);
        chk("rst_seq_out", 32'(bus_if.o_dprio_out), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 1'b1, 16'h0002, 16'h0000, bc, rm);
        chk("rst_seq_rd_busy", 32'(bc), RD_LAT);
        chk("rst_seq_rd_data", 32'(bus_if.o_dprio_out), 32'h0000);
        @(posedge clk); #1;

        // Write request held across completion: two windows, one idle cycle between
        bus_if.i_dprio_wren = 1'b1;
        bus_if.i_dprio_addr = 16'h0004;
        bus_if.i_dprio_data = 16'h1111;
        bc = 0;
        while (!bus_if.o_dprio_busy && bc < 8) begin
            @(posedge clk); #1; bc++;
        end
        run_hi1 = 0;
        while (bus_if.o_dprio_busy && run_hi1 < 20) begin
            run_hi1++; @(posedge clk); #1;
        end
        run_lo = 0;
        while (!bus_if.o_dprio_busy && run_lo < 20) begin
            run_lo++; @(posedge clk); #1;
        end
        bus_if.i_dprio_wren = 1'b0;
        run_hi2 = 0;
        while (bus_if.o_dprio_busy && run_hi2 < 20) begin
            run_hi2++; @(posedge clk); #1;
        end
        chk("b2b_first_window", 32'(run_hi1), WR_LAT);
        chk("b2b_gap", 32'(run_lo), 32'd1);
        chk("b2b_second_window", 32'(run_hi2), WR_LAT);
        @(posedge clk); #1;
        chk("b2b_no_third", 32'(bus_if.o_dprio_busy), 32'd0);
        do_op(1'b0, 1'b1, 16'h0004, 16'h0000, bc, rm);
        chk("b2b_readback", 32'(bus_if.o_dprio_out), 32'h1111);
        @(posedge clk); #1;

        // Random accesses against the word-array model, from a fresh reset
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NREGS; k++) model_mem[k] = 16'h0000;
        model_out = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            a  = 16'($urandom_range(0, 19));
            d  = 16'($urandom);
            op = int'($urandom_range(0, 2));
            do_op(op != 1, op != 0, a, d, bc, rm);
            in_rng = (a < NREGS);
            chk($sformatf("rnd%0d_remap", n), 32'(rm), in_rng ? 32'(a) : 32'hfff);
            if (!in_rng) begin
                chk($sformatf("rnd%0d_busy", n), 32'(bc), 32'd0);
            end else if (op != 1) begin
                if (a != 0) model_mem[a] = d;
                chk($sformatf("rnd%0d_busy", n), 32'(bc), WR_LAT);
            end else begin
                model_out = (a == 0) ? ID : model_mem[a];
                chk($sformatf("rnd%0d_busy", n), 32'(bc), RD_LAT);
            end
            chk($sformatf("rnd%0d_out", n), 32'(bus_if.o_dprio_out), 32'(model_out));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
